// File: rtl/stepper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stepper_pkg: FSM states, drive modes and coil phase table           |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_TWO  = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;

  // Entry 0 is the rightmost element; coil order {B',A',B,A}.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

endpackage
`default_nettype wire

// File: rtl/stepper_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stepper_phase_gen: phase index with mode snap, wrap step and lookup |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module stepper_phase_gen
  import stepper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance_i,
  input  logic       dir_i,
  input  logic [1:0] mode_i,
  input  logic       snap_i,
  output logic [3:0] phase_o
);

  logic [2:0] idx_q, idx_d;
  logic [2:0] delta;

  always_comb begin
    delta = (mode_i == MODE_HALF) ? 3'd1 : 3'd2;
    idx_d = idx_q;
    if (snap_i) begin
      // Full-step modes live on odd (two-phase) or even (wave) entries only.
      case (mode_i)
        MODE_WAVE: idx_d = {idx_q[2:1], 1'b0};
        MODE_HALF: idx_d = idx_q;
        default:   idx_d = {idx_q[2:1], 1'b1};
      endcase
    end else if (advance_i) begin
      idx_d = dir_i ? (idx_q + delta) : (idx_q - delta);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= 3'd1;
    else     idx_q <= idx_d;
  end

  assign phase_o = PHASE_TABLE[idx_q];

endmodule
`default_nettype wire

// File: rtl/stepper_seq_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stepper_seq_driver: start/abort sequencer with period/step/stroke   |
// | counters driving stepper_phase_gen. Revision: 1.0                   |
// +--------------------------------------------------------------------+
module stepper_seq_driver
  import stepper_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 12,
  parameter int STROKE_W = 4,
  parameter int HOLD_EN  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [1:0]          mode_i,
  input  logic                dir_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [COUNT_W-1:0]  steps_i,
  input  logic [STROKE_W-1:0] strokes_i,
  output logic                busy_o,
  output logic                step_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic [3:0]          phase_o
);

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                dir_q, dir_d;
  logic [PERIOD_W-1:0] period_q, period_d, per_cnt_q, per_cnt_d;
  logic [COUNT_W-1:0]  steps_q, steps_d, step_cnt_q, step_cnt_d;
  logic [STROKE_W-1:0] strokes_q, strokes_d, stroke_cnt_q, stroke_cnt_d;
  logic                step_q, step_d, aborted_q, aborted_d, ran_q, ran_d;
  logic                advance, snap;
  logic [1:0]          gen_mode;
  logic [3:0]          table_phase;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    period_d     = period_q;
    per_cnt_d    = per_cnt_q;
    steps_d      = steps_q;
    step_cnt_d   = step_cnt_q;
    strokes_d    = strokes_q;
    stroke_cnt_d = stroke_cnt_q;
    ran_d        = ran_q;
    step_d       = 1'b0;
    aborted_d    = 1'b0;
    advance      = 1'b0;
    snap         = 1'b0;
    gen_mode     = mode_q;
    case (state_q)
      ST_IDLE: begin
        gen_mode = mode_i;
        if (start_i) begin
          snap         = 1'b1;
          ran_d        = 1'b1;
          mode_d       = mode_i;
          dir_d        = dir_i;
          period_d     = (period_i == '0) ? PERIOD_W'(1) : period_i;
          steps_d      = steps_i;
          strokes_d    = strokes_i;
          per_cnt_d    = '0;
          step_cnt_d   = '0;
          stroke_cnt_d = '0;
          state_d      = (steps_i == '0 || strokes_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over a step due on the same edge.
        if (abort_i) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (stroke_cnt_q == strokes_q) begin
          state_d = ST_DONE;
        end else if (per_cnt_q == period_q - PERIOD_W'(1)) begin
          per_cnt_d = '0;
          advance   = 1'b1;
          step_d    = 1'b1;
          if (step_cnt_q == steps_q - COUNT_W'(1)) begin
            step_cnt_d   = '0;
            stroke_cnt_d = stroke_cnt_q + STROKE_W'(1);
            dir_d        = ~dir_q;
          end else begin
            step_cnt_d = step_cnt_q + COUNT_W'(1);
          end
        end else begin
          per_cnt_d = per_cnt_q + PERIOD_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_WAVE;
      dir_q        <= 1'b0;
      period_q     <= '0;
      per_cnt_q    <= '0;
      steps_q      <= '0;
      step_cnt_q   <= '0;
      strokes_q    <= '0;
      stroke_cnt_q <= '0;
      ran_q        <= 1'b0;
      step_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      period_q     <= period_d;
      per_cnt_q    <= per_cnt_d;
      steps_q      <= steps_d;
      step_cnt_q   <= step_cnt_d;
      strokes_q    <= strokes_d;
      stroke_cnt_q <= stroke_cnt_d;
      ran_q        <= ran_d;
      step_q       <= step_d;
      aborted_q    <= aborted_d;
    end
  end

  stepper_phase_gen u_phase_gen (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance),
    .dir_i     (dir_q),
    .mode_i    (gen_mode),
    .snap_i    (snap),
    .phase_o   (table_phase)
  );

  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);
  assign step_o    = step_q;
  assign aborted_o = aborted_q;
  assign phase_o   = (state_q == ST_RUN || (HOLD_EN != 0 && ran_q)) ? table_phase : 4'b0000;

endmodule
`default_nettype wire
